// File: rtl/ahb_slave_port_arbiter_if.sv
// Bundle of per-master request/transfer signals and arbiter select outputs
// for one shared AHB slave port.
//   master modport : request side (drives req/lock/htrans/hburst/hready)
//   slave modport  : arbiter side (drives addr_sel/data_sel/master_id)
interface ahb_slave_port_arbiter_if #(
    parameter int unsigned CHANNEL_NUM = 2,
    parameter int unsigned ID_W        = $clog2(CHANNEL_NUM)
);
    logic [CHANNEL_NUM-1:0]      req;
    logic [CHANNEL_NUM-1:0]      lock;
    logic [CHANNEL_NUM-1:0][1:0] htrans;
    logic [CHANNEL_NUM-1:0][2:0] hburst;
    logic                        hready;
    logic [CHANNEL_NUM-1:0]      addr_sel;
    logic [CHANNEL_NUM-1:0]      data_sel;
    logic [ID_W-1:0]             master_id;

    modport master (
        output req, lock, htrans, hburst, hready,
        input  addr_sel, data_sel, master_id
    );

    modport slave (
        input  req, lock, htrans, hburst, hready,
        output addr_sel, data_sel, master_id
    );
endinterface

// File: rtl/ahb_slave_port_arbiter.sv
// Round-robin arbiter for one AHB slave port shared by CHANNEL_NUM masters.
// Produces a one-hot address-phase select, a one-transfer-lagged one-hot
// data-phase select and the encoded owner id. Grants are held across fixed
// length bursts; grant changes only on hready-high cycles.
// Optional feature: define AHB_ARB_LOCK_EN to hold the grant while the owner
// asserts lock together with req.
// Ports:
//   hclk, hresetn : clock, asynchronous active-low reset
//   bus (slave)   : req, lock, htrans, hburst, hready in;
//                   addr_sel, data_sel, master_id out (all registered)
module ahb_slave_port_arbiter #(
    parameter int unsigned CHANNEL_NUM = 2,
    parameter int unsigned ID_W        = $clog2(CHANNEL_NUM)
) (
    input  logic                     hclk,
    input  logic                     hresetn,
    ahb_slave_port_arbiter_if.slave  bus
);
    localparam logic [1:0] HT_IDLE   = 2'd0;
    localparam logic [1:0] HT_BUSY   = 2'd1;
    localparam logic [1:0] HT_NONSEQ = 2'd2;
    localparam logic [1:0] HT_SEQ    = 2'd3;
    localparam logic [2:0] HB_SINGLE = 3'd0;

    typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_BURST} state_e;

    state_e                 state_q, state_d;
    logic [ID_W-1:0]        ptr_q, ptr_d;
    logic [ID_W-1:0]        master_id_q, master_id_d;
    logic [3:0]             beats_q, beats_d;
    logic [CHANNEL_NUM-1:0] addr_sel_q, addr_sel_d;
    logic [CHANNEL_NUM-1:0] data_sel_q, data_sel_d;

    logic [ID_W-1:0]        winner_c;
    logic                   any_req_c;
    logic                   others_req_c;
    logic [CHANNEL_NUM-1:0] own_mask_c;
    logic [1:0]             own_trans_c;
    logic [2:0]             own_burst_c;
    logic [3:0]             burst_len_c;
    logic                   burst_load_c;
    logic                   lock_hold_c;
    logic                   rearb_c;
    logic                   end_rearb_c;
    logic                   do_arb_c;

    // Round-robin scan starting at the pointer, wrapping modulo CHANNEL_NUM
    always_comb begin
        int unsigned idx;
        logic        found;
        winner_c = '0;
        found    = 1'b0;
        idx      = 0;
        for (int i = 0; i < int'(CHANNEL_NUM); i++) begin
            idx = (32'(ptr_q) + 32'(i)) % CHANNEL_NUM;
            if (!found && bus.req[ID_W'(idx)]) begin
                found    = 1'b1;
                winner_c = ID_W'(idx);
            end
        end
    end

    // Owner-side decode shared by the FSM and output logic
    always_comb begin
        any_req_c    = |bus.req;
        own_mask_c   = CHANNEL_NUM'(1) << master_id_q;
        others_req_c = |(bus.req & ~own_mask_c);
        own_trans_c  = bus.htrans[master_id_q];
        own_burst_c  = bus.hburst[master_id_q];
        case (own_burst_c)
            3'd2, 3'd3: burst_len_c = 4'd3;
            3'd4, 3'd5: burst_len_c = 4'd7;
            3'd6, 3'd7: burst_len_c = 4'd15;
            default:    burst_len_c = 4'd0;
        endcase
        burst_load_c = (own_trans_c == HT_NONSEQ) && (burst_len_c != 4'd0);
`ifdef AHB_ARB_LOCK_EN
        lock_hold_c  = bus.lock[master_id_q] && bus.req[master_id_q];
`else
        lock_hold_c  = 1'b0;
`endif
        rearb_c      = !lock_hold_c &&
                       (!bus.req[master_id_q] ||
                        (others_req_c &&
                         ((own_trans_c == HT_IDLE) ||
                          ((own_trans_c == HT_NONSEQ) && (own_burst_c == HB_SINGLE)))));
        // Last burst beat just completed: the boundary itself allows a handover
        end_rearb_c  = !lock_hold_c && (!bus.req[master_id_q] || others_req_c);
    end

`ifndef AHB_ARB_LOCK_EN
    logic unused_lock;
    assign unused_lock = ^bus.lock;
`endif

    // State register
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            beats_q     <= '0;
            addr_sel_q  <= '0;
            data_sel_q  <= '0;
            master_id_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            beats_q     <= beats_d;
            addr_sel_q  <= addr_sel_d;
            data_sel_q  <= data_sel_d;
            master_id_q <= master_id_d;
        end
    end

    // Next-state and burst counter
    always_comb begin
        state_d  = state_q;
        beats_d  = beats_q;
        do_arb_c = 1'b0;
        if (bus.hready) begin
            case (state_q)
                ST_IDLE: begin
                    if (any_req_c) begin
                        do_arb_c = 1'b1;
                        state_d  = ST_GRANT;
                    end
                end
                ST_BURST: begin
                    if (own_trans_c == HT_SEQ) begin
                        beats_d = beats_q - 4'd1;
                        if (beats_q <= 4'd1) begin
                            beats_d = '0;
                            state_d = ST_GRANT;
                            if (end_rearb_c) begin
                                do_arb_c = 1'b1;
                                state_d  = any_req_c ? ST_GRANT : ST_IDLE;
                            end
                        end
                    end else if (own_trans_c != HT_BUSY) begin
                        // Early termination: re-evaluate as a plain grant
                        beats_d = '0;
                        state_d = ST_GRANT;
                        if (burst_load_c) begin
                            beats_d = burst_len_c;
                            state_d = ST_BURST;
                        end else if (rearb_c) begin
                            do_arb_c = 1'b1;
                            state_d  = any_req_c ? ST_GRANT : ST_IDLE;
                        end
                    end
                end
                default: begin
                    if (burst_load_c) begin
                        beats_d = burst_len_c;
                        state_d = ST_BURST;
                    end else if (rearb_c) begin
                        do_arb_c = 1'b1;
                        state_d  = any_req_c ? ST_GRANT : ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Select outputs and round-robin pointer
    always_comb begin
        addr_sel_d  = addr_sel_q;
        data_sel_d  = data_sel_q;
        master_id_d = master_id_q;
        ptr_d       = ptr_q;
        if (bus.hready) begin
            data_sel_d = ((own_trans_c == HT_NONSEQ) || (own_trans_c == HT_SEQ)) ?
                         addr_sel_q : '0;
            if (do_arb_c) begin
                if (any_req_c) begin
                    addr_sel_d  = CHANNEL_NUM'(1) << winner_c;
                    master_id_d = winner_c;
                    ptr_d       = (winner_c == ID_W'(CHANNEL_NUM - 1)) ?
                                  '0 : winner_c + ID_W'(1);
                end else begin
                    addr_sel_d  = '0;
                    master_id_d = '0;
                end
            end
        end
    end

    assign bus.addr_sel  = addr_sel_q;
    assign bus.data_sel  = data_sel_q;
    assign bus.master_id = master_id_q;
endmodule

// File: tb/tb_ahb_slave_port_arbiter.sv
// Self-checking bench for ahb_slave_port_arbiter with two masters.
module tb_ahb_slave_port_arbiter;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] NS   = 2'd2;
    localparam logic [1:0] SEQ  = 2'd3;
    localparam logic [2:0] SGL  = 3'd0;
    localparam logic [2:0] INC4 = 3'd3;
    localparam logic [2:0] WRP8 = 3'd4;
    localparam logic [2:0] INC8 = 3'd5;

    typedef struct packed {
        logic [1:0] addr;
        logic [1:0] data;
        logic       id;
    } exp_t;

    logic hclk;
    logic hresetn;
    int   n_checks;
    int   n_errors;
    exp_t exp_q[$];

    ahb_slave_port_arbiter_if #(.CHANNEL_NUM(2)) bus ();

    ahb_slave_port_arbiter #(.CHANNEL_NUM(2)) dut (
        .hclk    (hclk),
        .hresetn (hresetn),
        .bus     (bus)
    );

    initial begin
        hclk = 1'b0;
        forever #5 hclk = ~hclk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input exp_t e);
        check({tag, ".addr_sel"},  32'(bus.addr_sel),  32'(e.addr));
        check({tag, ".data_sel"},  32'(bus.data_sel),  32'(e.data));
        check({tag, ".master_id"}, 32'(bus.master_id), 32'(e.id));
    endtask

    // Drive one cycle of stimulus, queue its expected outputs, compare after the edge
    task automatic step(input logic [1:0] r, input logic [1:0] lk,
                        input logic [1:0] t0, input logic [2:0] b0,
                        input logic [1:0] t1, input logic [2:0] b1,
                        input logic rdy,
                        input logic [1:0] ea, input logic [1:0] ed, input logic ei,
                        input string tag);
        exp_t e;
        bus.req       = r;
        bus.lock      = lk;
        bus.htrans[0] = t0;
        bus.hburst[0] = b0;
        bus.htrans[1] = t1;
        bus.hburst[1] = b1;
        bus.hready    = rdy;
        e.addr = ea;
        e.data = ed;
        e.id   = ei;
        exp_q.push_back(e);
        @(posedge hclk);
        #1;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: scoreboard empty, got 0 entries expected 1", tag);
        end else begin
            e = exp_q.pop_front();
            check_outputs(tag, e);
        end
    endtask

    task automatic apply_reset();
        exp_t z;
        z = '0;
        bus.req    = '0;
        bus.lock   = '0;
        bus.htrans = '0;
        bus.hburst = '0;
        bus.hready = 1'b1;
        hresetn    = 1'b0;
        repeat (2) @(posedge hclk);
        #1;
        check_outputs("reset", z);
        hresetn = 1'b1;
    endtask

    initial begin
        exp_t z;
        z        = '0;
        n_checks = 0;
        n_errors = 0;
        hresetn  = 1'b0;
        #2;
        apply_reset();

        // First grant and data phase
        step(2'b01, 2'b00, IDLE, SGL, IDLE, SGL, 1'b1, 2'b01, 2'b00, 1'b0, "grant0");
        step(2'b01, 2'b00, NS,   SGL, IDLE, SGL, 1'b1, 2'b01, 2'b01, 1'b0, "ns0");
        step(2'b01, 2'b00, IDLE, SGL, IDLE, SGL, 1'b1, 2'b01, 2'b00, 1'b0, "idle0");

        // Alternating SINGLE traffic
        step(2'b11, 2'b00, NS, SGL, NS, SGL, 1'b1, 2'b10, 2'b01, 1'b1, "alt1");
        step(2'b11, 2'b00, NS, SGL, NS, SGL, 1'b1, 2'b01, 2'b10, 1'b0, "alt2");
        step(2'b11, 2'b00, NS, SGL, NS, SGL, 1'b1, 2'b10, 2'b01, 1'b1, "alt3");
        step(2'b11, 2'b00, NS, SGL, NS, SGL, 1'b1, 2'b01, 2'b10, 1'b0, "alt4");

        // INCR4 from master 0 with a wait state on beat 2
        step(2'b11, 2'b00, NS,  INC4, NS, SGL, 1'b1, 2'b01, 2'b01, 1'b0, "incr4_b1");
        step(2'b11, 2'b00, SEQ, INC4, NS, SGL, 1'b0, 2'b01, 2'b01, 1'b0, "incr4_wait");
        step(2'b11, 2'b00, SEQ, INC4, NS, SGL, 1'b1, 2'b01, 2'b01, 1'b0, "incr4_b2");
        step(2'b11, 2'b00, SEQ, INC4, NS, SGL, 1'b1, 2'b01, 2'b01, 1'b0, "incr4_b3");
        step(2'b11, 2'b00, SEQ, INC4, NS, SGL, 1'b1, 2'b10, 2'b01, 1'b1, "incr4_b4");

        // WRAP8 from master 1 terminated early by IDLE
        step(2'b11, 2'b00, NS, SGL, NS,   WRP8, 1'b1, 2'b10, 2'b10, 1'b1, "wrap8_b1");
        step(2'b11, 2'b00, NS, SGL, SEQ,  WRP8, 1'b1, 2'b10, 2'b10, 1'b1, "wrap8_b2");
        step(2'b11, 2'b00, NS, SGL, SEQ,  WRP8, 1'b1, 2'b10, 2'b10, 1'b1, "wrap8_b3");
        step(2'b11, 2'b00, NS, SGL, IDLE, WRP8, 1'b1, 2'b01, 2'b00, 1'b0, "wrap8_term");

        // Locked SINGLEs from master 0
`ifdef AHB_ARB_LOCK_EN
        step(2'b11, 2'b01, NS, SGL, NS, SGL, 1'b1, 2'b01, 2'b01, 1'b0, "lock1");
        step(2'b11, 2'b01, NS, SGL, NS, SGL, 1'b1, 2'b01, 2'b01, 1'b0, "lock2");
        step(2'b11, 2'b01, NS, SGL, NS, SGL, 1'b1, 2'b01, 2'b01, 1'b0, "lock3");
        step(2'b11, 2'b00, NS, SGL, NS, SGL, 1'b1, 2'b10, 2'b01, 1'b1, "unlock");
`else
        step(2'b11, 2'b01, NS, SGL, NS, SGL, 1'b1, 2'b10, 2'b01, 1'b1, "lock1");
        step(2'b11, 2'b01, NS, SGL, NS, SGL, 1'b1, 2'b01, 2'b10, 1'b0, "lock2");
        step(2'b11, 2'b01, NS, SGL, NS, SGL, 1'b1, 2'b10, 2'b01, 1'b1, "lock3");
        step(2'b11, 2'b00, NS, SGL, NS, SGL, 1'b1, 2'b01, 2'b10, 1'b0, "unlock");
`endif

        // Asynchronous reset in the middle of an INCR8
        apply_reset();
        step(2'b01, 2'b00, IDLE, SGL,  IDLE, SGL, 1'b1, 2'b01, 2'b00, 1'b0, "r_grant0");
        step(2'b01, 2'b00, NS,   INC8, IDLE, SGL, 1'b1, 2'b01, 2'b01, 1'b0, "r_incr8_b1");
        step(2'b01, 2'b00, SEQ,  INC8, IDLE, SGL, 1'b1, 2'b01, 2'b01, 1'b0, "r_incr8_b2");
        hresetn = 1'b0;
        #1;
        check_outputs("async_reset", z);
        #2;
        bus.req    = 2'b10;
        bus.htrans = '0;
        bus.hburst = '0;
        hresetn    = 1'b1;
        step(2'b10, 2'b00, IDLE, SGL, IDLE, SGL, 1'b1, 2'b10, 2'b00, 1'b1, "post_rst_grant");
        step(2'b10, 2'b00, IDLE, SGL, NS,   SGL, 1'b1, 2'b10, 2'b10, 1'b1, "post_rst_ns");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls
    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish before 100000");
        $fatal(1);
    end
endmodule

// File: doc/ahb_slave_port_arbiter.md
# ahb_slave_port_arbiter

Round-robin arbiter for one AHB slave port shared by `CHANNEL_NUM` masters. It generates the one-hot select for the address-phase master-to-slave payload mux and a one-cycle-lagged one-hot select for the data-phase mux. Grants are held across fixed-length bursts and optional locked sequences. Grant changes happen only on AHB transfer boundaries (`hready` high).

## Interface
- `CHANNEL_NUM`, 2: number of requesting masters (2..16).
- `ID_W`, `$clog2(CHANNEL_NUM)`: width of encoded owner id.
- `hclk`  in  1  bus clock; all state updates on its rising edge.
- `hresetn`  in  1  asynchronous, active-low reset.
- `req`  in  [CHANNEL_NUM]  per-master bus request.
- `lock`  in  [CHANNEL_NUM]  per-master HMASTLOCK.
- `htrans`  in  [CHANNEL_NUM][2]  per-master HTRANS (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
- `hburst`  in  [CHANNEL_NUM][3]  per-master HBURST.
- `hready`  in  1  slave HREADYOUT; 1 = current data phase completes this cycle.
- `addr_sel`  out  [CHANNEL_NUM]  one-hot address-phase grant; all-zero = no owner.
- `data_sel`  out  [CHANNEL_NUM]  one-hot data-phase select; all-zero = no active data phase.
- `master_id`  out  ID_W  encoded index of `addr_sel` (0 when no owner).

## Operation
- All outputs registered. Reset values: `addr_sel`=0, `data_sel`=0, `master_id`=0. State is IDLE, the RR pointer is 0, and `beats_left`=0.
- States:
  - IDLE: no owner.
  - GRANT: the owner holds the bus but is not inside a counted burst.
  - BURST: the owner is inside an INCR4/8/16 or WRAP4/8/16 burst.
- RR winner: the first set `req[i]` scanning from pointer `p` upward and wrapping modulo `CHANNEL_NUM`. On every new grant, `p` <= winner+1, wrapping to 0 at `CHANNEL_NUM`.
- All transitions are evaluated only when `hready`=1. With `hready`=0, all state and outputs hold.
- IDLE:
  - Any `req` set: grant the RR winner and go to GRANT.
  - No `req` set: stay in IDLE.
- GRANT, owner `o`:
  - `htrans[o]`=NONSEQ with a fixed-length `hburst`: load `beats_left` = len-1 (3, 7 or 15) and go to BURST.
  - Otherwise re-arbitrate when either condition holds:
    - `req[o]`=0.
    - Another `req` is set and `htrans[o]` is IDLE or NONSEQ-SINGLE.
  - Re-arbitration picks the RR winner (GRANT) or no winner (IDLE, `addr_sel`=0).
  - An INCR (undefined-length) burst may be broken between beats.
- BURST:
  - `htrans[o]`=SEQ: decrement `beats_left`. If it was 1 (now 0), the last beat has been accepted, so apply the GRANT re-arbitration rule in the same cycle.
  - `htrans[o]`=BUSY: no change.
  - `htrans[o]`=IDLE or NONSEQ: early termination. Clear `beats_left` and evaluate as GRANT, including loading a new burst on NONSEQ.
- `data_sel`: when `hready`=1, `data_sel` <= (`htrans[o]` is NONSEQ or SEQ) ? `addr_sel` : 0.
- Reset asserted mid-burst: all outputs clear immediately (asynchronous). After release, arbitration restarts from pointer 0.

## Timing
- Grant latency: `req` seen at an edge with `hready`=1 in IDLE gives `addr_sel` on the next cycle.
- Handover: the old owner's final address phase and the new owner's first address phase are on consecutive `hready`-high cycles, with no idle cycle inserted.
- `data_sel` lags `addr_sel` by exactly one accepted transfer. Across a handover, `data_sel` still selects the previous owner for its final data phase.
- `addr_sel` and `data_sel` are always one-hot or zero. `master_id` is updated in the same cycle as `addr_sel`.

## Configuration
- `AHB_ARB_LOCK_EN` defined:
  - While `lock[o]`=1 and `req[o]`=1, re-arbitration is suppressed in GRANT and at the end of BURST.
  - The grant is released on the first `hready`-high cycle where `lock[o]`=0 and the normal GRANT rule fires.
- Undefined: the `lock` input is ignored, apart from being kept as a port.

## Test plan
- Reset then `req`=2'b01, `hready`=1 -> next cycle `addr_sel`=01, `master_id`=0. One cycle after NONSEQ, `data_sel`=01.
- `req`=2'b11 held, both masters issuing SINGLE NONSEQ every cycle -> `addr_sel` alternates 01,10,01,10 and `data_sel` follows one cycle later.
- Master 0 issues an INCR4 burst while `req[1]`=1, with `hready` low on beat 2 -> `addr_sel` stays 01 for exactly 4 accepted beats (5 clocks). It becomes 10 on the cycle after the 4th beat is accepted.
- Master 1 issues WRAP8 and drops to IDLE after 3 beats while `req[0]`=1 -> the grant moves to 01 on that IDLE cycle and `beats_left` clears.
- With `AHB_ARB_LOCK_EN`, master 0 issues three locked SINGLEs while `req[1]`=1 -> `addr_sel`=01 throughout, switching to 10 only after `lock[0]` drops. Without the macro, the grant alternates each transfer.
- Assert `hresetn`=0 mid-INCR8 -> `addr_sel`, `data_sel` and `master_id` read 0 in the same cycle. After release with `req`=2'b10, the first grant is 10.
